i2s_rx_sample: RTL and testbench



---
 rtl/i2s_rx_sample.sv | 228 ++++++++++++++++++++++
 tb/tb_i2s_rx_sample.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_sample.sv
// I2S receiver: oversamples BCLK/LRCK/SDATA in audio_clk and deserialises
// one channel word per slot, emitting one 16-bit sample per LRCK frame.
module i2s_rx_sample #(
  parameter int SAMPLE_W = 16,
  parameter int CH_SEL   = 0,
  parameter int ERR_W    = 8
) (
  input  logic             audio_clk,
  input  logic             rst_n,
  input  logic             rx_en,
  input  logic             i2s_bclk,
  input  logic             i2s_lrck,
  input  logic             i2s_sdata,
  output logic             audio_en,
  output logic [15:0]      audio_data,
  output logic             locked,
  output logic [ERR_W-1:0] frame_err_cnt
);

  localparam int CNT_W = (SAMPLE_W > 2) ? $clog2(SAMPLE_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_e;

  logic bclk_meta_q, bclk_sync_q, bclk_prev_q;
  logic lrck_meta_q, lrck_sync_q;
  logic sdata_meta_q, sdata_sync_q;

  always_ff @(posedge audio_clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_meta_q  <= 1'b0;
      bclk_sync_q  <= 1'b0;
      bclk_prev_q  <= 1'b0;
      lrck_meta_q  <= 1'b0;
      lrck_sync_q  <= 1'b0;
      sdata_meta_q <= 1'b0;
      sdata_sync_q <= 1'b0;
    end else begin
      bclk_meta_q  <= i2s_bclk;
      bclk_sync_q  <= bclk_meta_q;
      bclk_prev_q  <= bclk_sync_q;
      lrck_meta_q  <= i2s_lrck;
      lrck_sync_q  <= lrck_meta_q;
      sdata_meta_q <= i2s_sdata;
      sdata_sync_q <= sdata_meta_q;
    end
  end

  logic bclk_rise;
  assign bclk_rise = bclk_sync_q & ~bclk_prev_q;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] shift_nxt;
  logic [SAMPLE_W-1:0] l_q, l_d;
  logic [SAMPLE_W-1:0] r_q, r_d;
  logic                ch_q, ch_d;
  logic                lrck_q, lrck_d;
  logic                lrck_seen_q, lrck_seen_d;
  logic                left_ok_q, left_ok_d;
  logic                locked_q, locked_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                word_done_q, word_done_d;
  logic                done_ch_q, done_ch_d;
  logic                lr_edge;

  // The first rise after reset only primes lrck_q; it is never an edge.
  assign lr_edge   = lrck_seen_q & (lrck_sync_q != lrck_q);
  assign shift_nxt = {shift_q[SAMPLE_W-2:0], sdata_sync_q};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    l_d         = l_q;
    r_d         = r_q;
    ch_d        = ch_q;
    lrck_d      = lrck_q;
    lrck_seen_d = lrck_seen_q;
    left_ok_d   = left_ok_q;
    locked_d    = locked_q;
    err_d       = err_q;
    word_done_d = 1'b0;
    done_ch_d   = done_ch_q;
    if (bclk_rise) begin
      lrck_d      = lrck_sync_q;
      lrck_seen_d = 1'b1;
    end
    if (!rx_en) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      locked_d  = 1'b0;
      left_ok_d = 1'b0;
    end else if (bclk_rise) begin
      unique case (state_q)
        IDLE: begin
          if (lr_edge) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            ch_d      = lrck_sync_q;
          end
        end
        SHIFT: begin
          if (lr_edge) begin
            if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
            locked_d  = 1'b0;
            left_ok_d = 1'b0;
            bit_cnt_d = '0;
            ch_d      = lrck_sync_q;
          end else begin
            shift_d = shift_nxt;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d   = '0;
              state_d     = WAIT;
              word_done_d = 1'b1;
              done_ch_d   = ch_q;
              if (ch_q) begin
                r_d = shift_nxt;
                if (left_ok_q) locked_d = 1'b1;
              end else begin
                l_d       = shift_nxt;
                left_ok_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        WAIT: begin
          if (lr_edge) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            ch_d      = lrck_sync_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge audio_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      l_q         <= '0;
      r_q         <= '0;
      ch_q        <= 1'b0;
      lrck_q      <= 1'b0;
      lrck_seen_q <= 1'b0;
      left_ok_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= '0;
      word_done_q <= 1'b0;
      done_ch_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      l_q         <= l_d;
      r_q         <= r_d;
      ch_q        <= ch_d;
      lrck_q      <= lrck_d;
      lrck_seen_q <= lrck_seen_d;
      left_ok_q   <= left_ok_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      word_done_q <= word_done_d;
      done_ch_q   <= done_ch_d;
    end
  end

  logic [15:0] l16, r16;

  if (SAMPLE_W >= 16) begin : g_wide
    assign l16 = l_q[SAMPLE_W-1 -: 16];
    assign r16 = r_q[SAMPLE_W-1 -: 16];
  end else begin : g_narrow
    assign l16 = {l_q, {(16-SAMPLE_W){1'b0}}};
    assign r16 = {r_q, {(16-SAMPLE_W){1'b0}}};
  end

  // 17-bit two's complement sum; dropping bit 0 is a floor divide by 2.
  logic [16:0] mono_sum;
  assign mono_sum = {l16[15], l16} + {r16[15], r16};

  logic        audio_en_q, audio_en_d;
  logic [15:0] audio_data_q, audio_data_d;

  always_comb begin
    audio_en_d   = 1'b0;
    audio_data_d = audio_data_q;
    if (word_done_q && locked_q && rx_en) begin
      if (CH_SEL == 0 && !done_ch_q) begin
        audio_en_d   = 1'b1;
        audio_data_d = l16;
      end else if (CH_SEL == 1 && done_ch_q) begin
        audio_en_d   = 1'b1;
        audio_data_d = r16;
      end else if (CH_SEL == 2 && done_ch_q) begin
        audio_en_d   = 1'b1;
        audio_data_d = mono_sum[16:1];
      end
    end
  end

  always_ff @(posedge audio_clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_en_q   <= 1'b0;
      audio_data_q <= '0;
    end else begin
      audio_en_q   <= audio_en_d;
      audio_data_q <= audio_data_d;
    end
  end

  assign audio_en      = audio_en_q;
  assign audio_data    = audio_data_q;
  assign locked        = locked_q;
  assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_i2s_rx_sample.sv
// Bench for i2s_rx_sample: left, right and mono instances share one I2S
// stream; a slot-level model predicts samples, lock and error count.
module tb_i2s_rx_sample;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rx_en, bclk, lrck, sdata;
  logic        en   [3];
  logic [15:0] dat  [3];
  logic        lk   [3];
  logic [7:0]  err  [3];

  i2s_rx_sample #(.SAMPLE_W(16), .CH_SEL(0), .ERR_W(8)) u0 (
    .audio_clk(clk), .rst_n(rst_n), .rx_en(rx_en),
    .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_sdata(sdata),
    .audio_en(en[0]), .audio_data(dat[0]),
    .locked(lk[0]), .frame_err_cnt(err[0]));

  i2s_rx_sample #(.SAMPLE_W(16), .CH_SEL(1), .ERR_W(8)) u1 (
    .audio_clk(clk), .rst_n(rst_n), .rx_en(rx_en),
    .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_sdata(sdata),
    .audio_en(en[1]), .audio_data(dat[1]),
    .locked(lk[1]), .frame_err_cnt(err[1]));

  i2s_rx_sample #(.SAMPLE_W(16), .CH_SEL(2), .ERR_W(8)) u2 (
    .audio_clk(clk), .rst_n(rst_n), .rx_en(rx_en),
    .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_sdata(sdata),
    .audio_en(en[2]), .audio_data(dat[2]),
    .locked(lk[2]), .frame_err_cnt(err[2]));

  int checks = 0;
  int fails  = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  bit          m_lock, m_lok, m_skip;
  int          m_err;
  logic [15:0] m_l;
  logic [15:0] last [3];
  bit          cur_lr;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] mono(input logic [15:0] l,
                                       input logic [15:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    s = s >>> 1;
    return s[15:0];
  endfunction

  task automatic pop_cmp(input int k);
    logic [15:0] e;
    bit have;
    have = 1'b1;
    e = '0;
    case (k)
      0: if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
    endcase
    if (!have) begin
      checks++;
      fails++;
      $display("FAIL unexpected_pulse_ch%0d got=%0h exp=none", k, dat[k]);
    end else begin
      chk($sformatf("pulse_ch%0d", k), int'(dat[k]), int'(e));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++)
        if (en[k]) pop_cmp(k);
    end
  end

  // A slot of n BCLK periods carries n-1 data bits after the edge bit.
  task automatic model_slot(input int n, input logic [15:0] w,
                            input bit dis);
    if (m_skip) begin
      m_skip = 1'b0;
      return;
    end
    if (dis) begin
      m_lock = 1'b0;
      m_lok  = 1'b0;
      return;
    end
    if (n - 1 >= 16) begin
      if (!cur_lr) begin
        m_l   = w;
        m_lok = 1'b1;
        if (m_lock) begin
          q0.push_back(w);
          last[0] = w;
        end
      end else if (m_lok) begin
        m_lock = 1'b1;
        q1.push_back(w);
        last[1] = w;
        q2.push_back(mono(m_l, w));
        last[2] = mono(m_l, w);
      end
    end else begin
      if (m_err < 255) m_err++;
      m_lock = 1'b0;
      m_lok  = 1'b0;
    end
  endtask

  task automatic check_disabled();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dis_locked_ch%0d", k), int'(lk[k]), 0);
      chk($sformatf("dis_hold_ch%0d", k), int'(dat[k]), int'(last[k]));
    end
  endtask

  task automatic slot(input int n, input logic [15:0] w,
                      input int off, input int on);
    model_slot(n, w, off >= 0);
    for (int p = 0; p < n; p++) begin
      if (p == off) rx_en = 1'b0;
      if (p == on) rx_en = 1'b1;
      if (off >= 0 && p == off + 3) check_disabled();
      lrck = cur_lr;
      if (p >= 1 && p <= 16) sdata = w[16-p];
      else sdata = 1'($urandom_range(0, 1));
      bclk = 1'b0;
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    cur_lr = ~cur_lr;
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    slot(32, l, -1, -1);
    slot(32, r, -1, -1);
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_locked_ch%0d", tag, k), int'(lk[k]), int'(m_lock));
      chk($sformatf("%s_err_ch%0d", tag, k), int'(err[k]), m_err);
      chk($sformatf("%s_data_ch%0d", tag, k), int'(dat[k]), int'(last[k]));
    end
  endtask

  task automatic do_reset();
    chk("pre_reset_q0_empty", q0.size(), 0);
    chk("pre_reset_q1_empty", q1.size(), 0);
    chk("pre_reset_q2_empty", q2.size(), 0);
    bclk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_en_ch%0d", k), int'(en[k]), 0);
      chk($sformatf("rst_data_ch%0d", k), int'(dat[k]), 0);
      chk($sformatf("rst_locked_ch%0d", k), int'(lk[k]), 0);
      chk($sformatf("rst_err_ch%0d", k), int'(err[k]), 0);
      last[k] = '0;
    end
    m_lock = 1'b0;
    m_lok  = 1'b0;
    m_skip = 1'b1;
    m_err  = 0;
    m_l    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    rx_en  = 1'b1;
    bclk   = 1'b0;
    lrck   = 1'b1;
    sdata  = 1'b0;
    cur_lr = 1'b0;
    do_reset();

    for (int f = 0; f < 4; f++) begin
      frame(16'h1234, 16'hABCD);
      check_state($sformatf("basic_f%0d", f));
    end

    frame(16'h7FFE, 16'h0002);
    check_state("mono_pos");
    frame(16'h8000, 16'hFFFF);
    check_state("mono_neg");

    slot(10, 16'($urandom), -1, -1);
    slot(32, 16'h5A5A, -1, -1);
    check_state("short_left");
    frame(16'h1111, 16'h2222);
    frame(16'h3333, 16'h4444);
    check_state("relock");

    slot(32, 16'($urandom), 10, 16);
    slot(32, 16'($urandom), -1, -1);
    frame(16'hC001, 16'h0FF0);
    check_state("rx_en_resume");

    for (int i = 0; i < 300; i++) slot(8, 16'($urandom), -1, -1);
    frame(16'h0F0F, 16'hF0F0);
    frame(16'h1357, 16'h2468);
    check_state("err_sat");

    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 7) == 0)
        slot($urandom_range(3, 16), 16'($urandom), -1, -1);
      else
        slot($urandom_range(17, 32), 16'($urandom), -1, -1);
    end
    for (int i = 0; i < 4; i++) slot(32, 16'($urandom), -1, -1);
    check_state("random");

    if (!cur_lr) slot(32, 16'($urandom), -1, -1);
    do_reset();
    slot(32, 16'h9999, -1, -1);
    check_state("post_rst_skip");
    slot(32, 16'hFACE, -1, -1);
    slot(32, 16'h0BAD, -1, -1);
    check_state("post_rst_lock");
    slot(32, 16'h7777, -1, -1);
    slot(32, 16'h8888, -1, -1);
    check_state("post_rst_run");

    repeat (20) @(negedge clk);
    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);
    chk("end_q2_empty", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
